// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment driver with tear-free commit at frame boundaries.
// Optional leading-zero blanking is enabled by defining SEG_LZB_EN.
module seg_scan_ctrl #(
  parameter int unsigned DIV = 260000
) (
  input  logic        clock,
  input  logic        rst,
  input  logic [31:0] val,
  input  logic        ld,
  input  logic        page,
  output logic        pend,
  output logic [3:0]  an,
  output logic [7:0]  seg
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [31:0]     pend_word_q, pend_word_d;
  logic [31:0]     disp_q, disp_d;
  logic            page_q, page_d;
  logic            pend_q, pend_d;
  logic [3:0]      an_q, an_d;
  logic [7:0]      seg_q, seg_d;

  logic            tick;
  logic            frame_end;
  logic [15:0]     half;
  logic [3:0]      nib;
  logic [7:0]      glyph;
  logic            blank;

  assign tick      = (cnt_q == CntMax);
  assign frame_end = tick && (idx_q == 2'd3);

  always_comb begin
    cnt_d       = tick ? '0 : cnt_q + 1'b1;
    idx_d       = tick ? idx_q + 2'd1 : idx_q;
    pend_word_d = pend_word_q;
    disp_d      = disp_q;
    page_d      = page_q;
    pend_d      = pend_q;
    // Commit sees the pre-edge pending word; a coincident load re-arms pend.
    if (frame_end) begin
      page_d = page;
      if (pend_q) begin
        disp_d = pend_word_q;
        pend_d = 1'b0;
      end
    end
    if (ld) begin
      pend_word_d = val;
      pend_d      = 1'b1;
    end
  end

  always_comb begin
    half = page_q ? disp_q[31:16] : disp_q[15:0];
    nib  = half[{idx_q, 2'b00} +: 4];
    unique case (nib)
      4'h0:    glyph = 8'h03;
      4'h1:    glyph = 8'h9F;
      4'h2:    glyph = 8'h25;
      4'h3:    glyph = 8'h0D;
      4'h4:    glyph = 8'h99;
      4'h5:    glyph = 8'h49;
      4'h6:    glyph = 8'h41;
      4'h7:    glyph = 8'h1F;
      4'h8:    glyph = 8'h01;
      4'h9:    glyph = 8'h09;
      4'hA:    glyph = 8'h11;
      4'hB:    glyph = 8'hC1;
      4'hC:    glyph = 8'h63;
      4'hD:    glyph = 8'h85;
      4'hE:    glyph = 8'h61;
      default: glyph = 8'h71;
    endcase
`ifdef SEG_LZB_EN
    // A digit is leading-zero when it and every nibble above it are zero.
    blank = (idx_q != 2'd0) && ((half >> {idx_q, 2'b00}) == 16'd0);
`else
    blank = 1'b0;
`endif
    an_d  = ~(4'b1000 >> idx_q);
    seg_d = blank ? 8'hFF : glyph;
    if (idx_q == 2'd0 && page_q) begin
      seg_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      idx_q       <= 2'd0;
      pend_word_q <= 32'd0;
      disp_q      <= 32'd0;
      page_q      <= 1'b0;
      pend_q      <= 1'b0;
      an_q        <= 4'b1111;
      seg_q       <= 8'hFF;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      pend_word_q <= pend_word_d;
      disp_q      <= disp_d;
      page_q      <= page_d;
      pend_q      <= pend_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign pend = pend_q;
  assign an   = an_q;
  assign seg  = seg_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed vector table, corner sequences and random loads
// against a cycle-count based reference model.
module tb_seg_scan_ctrl;

  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  logic        clock;
  logic        rst;
  logic [31:0] val;
  logic        ld;
  logic        page;
  logic        pend;
  logic [3:0]  an;
  logic [7:0]  seg;

  seg_scan_ctrl #(.DIV(DIV)) dut (
    .clock (clock),
    .rst   (rst),
    .val   (val),
    .ld    (ld),
    .page  (page),
    .pend  (pend),
    .an    (an),
    .seg   (seg)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int total;
  int bad;

  // Reference model: position in the scan derived from edges since reset release.
  int          t;
  logic        m_pend;
  logic [31:0] m_pw;
  logic [31:0] m_disp;
  logic        m_pg;
  logic [3:0]  e_an;
  logic [7:0]  e_seg;
  logic [7:0]  glyph [16];

  typedef struct {
    int          n;
    logic        l;
    logic [31:0] v;
    logic        p;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        pend;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0d, time %0t)", name, act, exp, t, $time);
    end
  endtask

  function automatic logic [7:0] exp_seg(input int digit, input logic [31:0] w, input logic pg);
    logic [15:0] h;
    logic [7:0]  s;
    int          nib;
    int          hi;
    h   = pg ? w[31:16] : w[15:0];
    nib = int'((h >> (4 * digit)) & 16'hF);
    s   = glyph[nib];
    hi  = 0;
    for (int i = 0; i < 4; i++) begin
      if (((h >> (4 * i)) & 16'hF) != 16'd0) hi = i;
    end
`ifdef SEG_LZB_EN
    if (digit > hi) s = 8'hFF;
`endif
    if (digit == 0 && pg) s[0] = 1'b0;
    return s;
  endfunction

  task automatic model_reset();
    t      = 0;
    m_pend = 1'b0;
    m_pw   = 32'd0;
    m_disp = 32'd0;
    m_pg   = 1'b0;
  endtask

  task automatic step(input logic l, input logic [31:0] v, input logic p);
    int digit;
    ld   = l;
    val  = v;
    page = p;
    @(posedge clock);
    digit = (t / DIV) % 4;
    e_an  = 4'b1111;
    e_an[3 - digit] = 1'b0;
    e_seg = exp_seg(digit, m_disp, m_pg);
    if ((t % FRAME) == FRAME - 1) begin
      m_pg = p;
      if (m_pend) begin
        m_disp = m_pw;
        m_pend = 1'b0;
      end
    end
    if (l) begin
      m_pw   = v;
      m_pend = 1'b1;
    end
    t++;
    #1;
    check("model_an", 32'(an), 32'(e_an));
    check("model_seg", 32'(seg), 32'(e_seg));
    check("model_pend", 32'(pend), 32'(m_pend));
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b0;
    #1;
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'hFF);
    check("rst_pend", 32'(pend), 32'h0);
    @(negedge clock);
    @(negedge clock);
    check("rst_hold_an", 32'(an), 32'hF);
    check("rst_hold_seg", 32'(seg), 32'hFF);
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    logic seen_b;
    logic [31:0] v;
    logic        p;
    total = 0;
    bad   = 0;
    glyph = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
              8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
    tbl[0]  = '{1, 1'b1, 32'h1234_5678, 1'b0, 4'h7, 8'h03, 1'b1};
    tbl[1]  = '{3, 1'b0, 32'h0,         1'b0, 4'h7, 8'h03, 1'b1};
    tbl[2]  = '{4, 1'b0, 32'h0,         1'b0, 4'hB, 8'h03, 1'b1};
    tbl[3]  = '{4, 1'b0, 32'h0,         1'b0, 4'hD, 8'h03, 1'b1};
    tbl[4]  = '{3, 1'b0, 32'h0,         1'b0, 4'hE, 8'h03, 1'b1};
    tbl[5]  = '{1, 1'b0, 32'h0,         1'b0, 4'hE, 8'h03, 1'b0};
    tbl[6]  = '{4, 1'b0, 32'h0,         1'b0, 4'h7, 8'h01, 1'b0};
    tbl[7]  = '{4, 1'b0, 32'h0,         1'b0, 4'hB, 8'h1F, 1'b0};
    tbl[8]  = '{4, 1'b0, 32'h0,         1'b0, 4'hD, 8'h41, 1'b0};
    tbl[9]  = '{3, 1'b0, 32'h0,         1'b0, 4'hE, 8'h49, 1'b0};
    tbl[10] = '{1, 1'b0, 32'h0,         1'b1, 4'hE, 8'h49, 1'b0};
    tbl[11] = '{4, 1'b0, 32'h0,         1'b1, 4'h7, 8'h98, 1'b0};
    tbl[12] = '{4, 1'b0, 32'h0,         1'b1, 4'hB, 8'h0D, 1'b0};
    tbl[13] = '{4, 1'b0, 32'h0,         1'b1, 4'hD, 8'h25, 1'b0};
    tbl[14] = '{4, 1'b0, 32'h0,         1'b1, 4'hE, 8'h9F, 1'b0};

    rst  = 1'b0;
    ld   = 1'b0;
    val  = 32'd0;
    page = 1'b0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check("por_an", 32'(an), 32'hF);
    check("por_seg", 32'(seg), 32'hFF);
    check("por_pend", 32'(pend), 32'h0);
    @(negedge clock);
    rst = 1'b1;

    // Directed table from reset release.
    for (int i = 0; i < 15; i++) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        step(tbl[i].l, tbl[i].v, tbl[i].p);
        check($sformatf("tbl%0d_an", i), 32'(an), 32'(tbl[i].an));
        check($sformatf("tbl%0d_seg", i), 32'(seg), 32'(tbl[i].seg));
        check($sformatf("tbl%0d_pend", i), 32'(pend), 32'(tbl[i].pend));
      end
    end

    // Two loads in one frame: only the later word is ever shown.
    do_reset();
    seen_b = 1'b0;
    step(1'b1, 32'h0000_AAAA, 1'b0);
    repeat (4) step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h0000_BBBB, 1'b0);
    for (int k = 0; k < 40; k++) begin
      step(1'b0, 32'h0, 1'b0);
      total++;
      if (seg == 8'h11) begin
        bad++;
        $display("FAIL overwritten_word_shown: got %h expected not 11", seg);
      end
      if (seg == 8'hC1) seen_b = 1'b1;
    end
    check("latest_word_shown", 32'(seen_b), 32'h1);

    // Load exactly on the frame-boundary edge.
    step(1'b1, 32'h0000_1111, 1'b0);
    while ((t % FRAME) != FRAME - 1) step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h0000_2222, 1'b0);
    check("bnd_pend_kept", 32'(pend), 32'h1);
    step(1'b0, 32'h0, 1'b0);
    check("bnd_old_commit", 32'(seg), 32'h9F);
    repeat (16) step(1'b0, 32'h0, 1'b0);
    check("bnd_new_next_frame", 32'(seg), 32'h25);
    check("bnd_pend_clear", 32'(pend), 32'h0);

    // Words with leading zeros (blanking checked by the model when enabled).
    step(1'b1, 32'h0000_0050, 1'b0);
    repeat (35) step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h0000_0000, 1'b0);
    repeat (35) step(1'b0, 32'h0, 1'b0);

    // Random loads and page changes, with one mid-frame reset.
    p = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      if (k == 700) begin
        step(1'b1, $urandom, p);
        repeat (5) step(1'b0, 32'h0, p);
        do_reset();
      end
      v = $urandom;
      v = v >> (4 * $urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) p = ~p;
      step(($urandom_range(0, 7) == 0), v, p);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
